// File: rtl/qcv_pkg.sv
// Shared types and constants for the QCV load/store unit.
// Holds the FSM states, access-size codes, byte masks and split/mask helpers.
package qcv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ1,
        ST_WAIT1,
        ST_REQ2,
        ST_WAIT2
    } lsu_state_e;

    typedef enum logic [1:0] {
        TYPE_WORD0 = 2'b00,
        TYPE_BYTE  = 2'b01,
        TYPE_HALF  = 2'b10,
        TYPE_WORD  = 2'b11
    } lsu_type_e;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    function automatic logic [3:0] type_mask(input logic [1:0] t);
        case (lsu_type_e'(t))
            TYPE_BYTE: type_mask = MASK_BYTE;
            TYPE_HALF: type_mask = MASK_HALF;
            default:   type_mask = MASK_WORD;
        endcase
    endfunction

    // An access splits when its byte lanes cross into the next word.
    function automatic logic is_split(input logic [1:0] t, input logic [1:0] off);
        case (lsu_type_e'(t))
            TYPE_BYTE: is_split = 1'b0;
            TYPE_HALF: is_split = (off == 2'd3);
            default:   is_split = (off != 2'd0);
        endcase
    endfunction

endpackage

// File: rtl/qcv_lsu_rdata_align.sv
// Combinational load-data extraction: shifts the two-word read window by the
// byte offset and zero- or sign-extends to 32 bits according to access size.
module qcv_lsu_rdata_align
    import qcv_pkg::*;
(
    input  logic [31:0] rdata_hi,
    input  logic [31:0] rdata_lo,
    input  logic [1:0]  offset,
    input  logic [1:0]  lsu_type,
    input  logic        sign_ext,
    output logic [31:0] rdata
);

    logic [63:0] shifted;

    always_comb begin
        shifted = {rdata_hi, rdata_lo} >> {offset, 3'b000};
        case (lsu_type_e'(lsu_type))
            TYPE_BYTE: rdata = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            TYPE_HALF: rdata = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default:   rdata = shifted[31:0];
        endcase
    end

endmodule

// File: rtl/qcv_lsu_misalign.sv
// Load/store unit bus front-end: splits misaligned accesses into two aligned
// bus transactions (or rejects them) and merges the load data back together.
module qcv_lsu_misalign
    import qcv_pkg::*;
#(
    parameter bit MISALIGN_EN   = 1'b1,
    parameter bit ERR_ON_SECOND = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [31:0] lsu_addr_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_resp_valid_o,
    output logic        load_err_o,
    output logic        store_err_o,
    output logic        misaligned_err_o,
    output logic [31:0] addr_last_o,
    output logic        busy_o
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata1_q;
    logic [1:0]  type_q;
    logic        we_q, sign_q, err1_q, mis_q;

    logic        accept, reject, split, phase2, fin, fin_err;
    logic [1:0]  off;
    logic [7:0]  be8;
    logic [63:0] wd64;
    logic [31:0] addr_lo, addr_hi, align_hi, align_lo, align_out;

    assign accept  = (state_q == ST_IDLE) && lsu_req_i;
    assign reject  = accept && !MISALIGN_EN && is_split(lsu_type_i, lsu_addr_i[1:0]);
    assign off     = addr_q[1:0];
    assign split   = is_split(type_q, off);
    assign be8     = {4'b0000, type_mask(type_q)} << off;
    assign wd64    = {32'h0, wdata_q} << {off, 3'b000};
    assign addr_lo = {addr_q[31:2], 2'b00};
    assign addr_hi = {addr_q[31:2] + 30'd1, 2'b00};

    always_comb begin
        state_d = state_q;
        fin     = 1'b0;
        fin_err = 1'b0;
        case (state_q)
            ST_IDLE:  if (lsu_req_i && !reject) state_d = ST_REQ1;
            ST_REQ1:  if (data_gnt_i) state_d = ST_WAIT1;
            ST_WAIT1: begin
                if (data_rvalid_i) begin
                    if (split && !(ERR_ON_SECOND && data_err_i)) begin
                        state_d = ST_REQ2;
                    end else begin
                        state_d = ST_IDLE;
                        fin     = 1'b1;
                        fin_err = data_err_i;
                    end
                end
            end
            ST_REQ2:  if (data_gnt_i) state_d = ST_WAIT2;
            ST_WAIT2: begin
                if (data_rvalid_i) begin
                    state_d = ST_IDLE;
                    fin     = 1'b1;
                    fin_err = err1_q | data_err_i;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata1_q <= '0;
            type_q   <= '0;
            we_q     <= 1'b0;
            sign_q   <= 1'b0;
            err1_q   <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mis_q   <= reject;
            if (accept) begin
                addr_q  <= lsu_addr_i;
                wdata_q <= lsu_wdata_i;
                type_q  <= lsu_type_i;
                we_q    <= lsu_we_i;
                sign_q  <= lsu_sign_ext_i;
            end
            if (state_q == ST_WAIT1 && data_rvalid_i) begin
                rdata1_q <= data_rdata_i;
                err1_q   <= data_err_i;
            end
        end
    end

    assign phase2       = (state_q == ST_REQ2);
    assign data_req_o   = (state_q == ST_REQ1) || phase2;
    assign data_addr_o  = data_req_o ? (phase2 ? addr_hi : addr_lo) : '0;
    assign data_be_o    = data_req_o ? (phase2 ? be8[7:4] : be8[3:0]) : '0;
    assign data_wdata_o = data_req_o ? (phase2 ? wd64[63:32] : wd64[31:0]) : '0;
    assign data_we_o    = data_req_o & we_q;

    // The final beat arrives live on the bus; a split load pairs it with the held first word.
    assign align_lo = (state_q == ST_WAIT2) ? rdata1_q : data_rdata_i;
    assign align_hi = (state_q == ST_WAIT2) ? data_rdata_i : '0;

    qcv_lsu_rdata_align u_align (
        .rdata_hi (align_hi),
        .rdata_lo (align_lo),
        .offset   (off),
        .lsu_type (type_q),
        .sign_ext (sign_q),
        .rdata    (align_out)
    );

    assign lsu_resp_valid_o = fin | mis_q;
    assign lsu_rdata_o      = (fin && !we_q) ? align_out : '0;
    assign load_err_o       = fin & fin_err & ~we_q;
    assign store_err_o      = fin & fin_err & we_q;
    assign misaligned_err_o = mis_q;
    assign addr_last_o      = (state_q == ST_WAIT2 && data_rvalid_i && data_err_i) ? addr_hi : addr_q;
    assign busy_o           = (state_q != ST_IDLE);

endmodule
